spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Single-port RAM controller directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid words and decodes din[9:8] as a command.
- Performs address latch, write and read operations on an internal byte-wide memory.
- Returns read bytes to the slave on dout/tx_valid for shifting out on MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; legal range 2..2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; legal range 1..8, because the address is carried in din[7:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  10  command word from SPI slave: [9:8] opcode, [7:0] address or data.
- rx_valid  input  1  din valid; may stay high for several cycles per word.
- dout  output  8  read data to SPI slave.
- tx_valid  output  1  dout valid; level, held until cleared.
- err  output  1  one-cycle pulse on an illegal or out-of-range command.

Behaviour:
- Reset (async, rst_n=0): dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_addr_vld=0, rd_addr_vld=0, rx_valid_d=0. Memory contents are not reset (X until written).
- Word acceptance:
  - rx_valid_d registers rx_valid every cycle.
  - accept = rx_valid & ~rx_valid_d, i.e. a rising edge of rx_valid.
  - Exactly one command executes per rx_valid high period, regardless of its length.
  - din is sampled on the accepting edge only.
- Latency: every effect (register update, memory write, dout, tx_valid, err) is visible after the same clock edge that accepts the word, i.e. 1 cycle after rx_valid rises.
- err default: err=0 on every cycle with no error.
- Opcode 00 WR_ADDR:
  - If din[7:0] < MEM_DEPTH: wr_addr <= din[ADDR_SIZE-1:0], wr_addr_vld <= 1.
  - Else: err=1; wr_addr and wr_addr_vld unchanged.
- Opcode 01 WR_DATA:
  - If wr_addr_vld: mem[wr_addr] <= din[7:0], then wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
  - Else: err=1, no write.
- Opcode 10 RD_ADDR:
  - If din[7:0] < MEM_DEPTH: rd_addr <= din[ADDR_SIZE-1:0], rd_addr_vld <= 1.
  - Else: err=1.
  - In both cases tx_valid <= 0.
- Opcode 11 RD_DATA:
  - If rd_addr_vld: dout <= mem[rd_addr], tx_valid <= 1, rd_addr <= rd_addr+1 with the same wrap rule.
  - Else: err=1; tx_valid <= 0; dout unchanged.
- tx_valid clearing:
  - Once set, tx_valid stays 1 until the next accepted word whose opcode is not 11, or reset.
  - A back-to-back RD_DATA reloads dout and keeps tx_valid=1.
- Read-after-write: RD_DATA to the address written by the immediately preceding WR_DATA returns the new data. Words are always accepted on distinct edges.
- Address wrap: auto-increment past MEM_DEPTH-1 returns to 0 with no error. For non-power-of-two depths the compare is against MEM_DEPTH-1, not a natural overflow.
- rx_valid high at reset release:
  - rx_valid_d starts at 0, so a high rx_valid on the first clock counts as a rising edge and is accepted.
  - The bench drives rx_valid=0 during reset.
- Reset mid-operation: the async assertion clears all listed registers immediately, including a pending tx_valid. Memory keeps its contents.
- State is held in wr_addr_vld/rd_addr_vld: a sequencing FSM {NO_ADDR, ADDR_OK} per port. Data commands are illegal in NO_ADDR. Address commands with an out-of-range value do not change state.

Test Plan:
- Write/readback:
  - Stimulus: 00_0x10, 01_0xA5, 10_0x10, 11_xx.
  - Response: dout=0xA5 and tx_valid=1 one cycle after the 4th rx_valid rise; err never asserted.
- Burst and wrap, MEM_DEPTH=256:
  - Stimulus: WR_ADDR 0xFE; WR_DATA 0x11, 0x22, 0x33; RD_ADDR 0xFE; three RD_DATA.
  - Response: reads return 0x11, 0x22, 0x33; the third comes from address 0x00.
- Long rx_valid:
  - Stimulus: hold rx_valid high 5 cycles with din=01_0x5A after WR_ADDR 0x03.
  - Response: exactly one write; wr_addr=0x04, not 0x08.
- Sequencing errors after reset:
  - Stimulus: send 11_xx, then 01_0x77.
  - Response: err pulses 1 cycle each; tx_valid stays 0; memory unchanged.
- Range error at MEM_DEPTH=200:
  - Stimulus: RD_ADDR 0xC8.
  - Response: err=1; rd_addr_vld stays 0. A following RD_DATA also raises err.
- tx_valid hold/clear and reset:
  - Stimulus: after a successful RD_DATA, send WR_ADDR.
  - Response: tx_valid drops after that edge.
  - Stimulus: separately, assert rst_n=0 mid-cycle while tx_valid=1.
  - Response: tx_valid=0 and dout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_ctrl
// Purpose  : Byte-wide single-port RAM controller sitting behind an SPI slave.
//            Each 10-bit word from the slave carries a 2-bit opcode in
//            din[9:8] and an address or data byte in din[7:0]:
//              00 WR_ADDR  latch write address
//              01 WR_DATA  write byte, post-increment write address
//              10 RD_ADDR  latch read address
//              11 RD_DATA  read byte to dout, post-increment read address
//            Exactly one command runs per rising edge of rx_valid.
// Ports    : clk       clock, rising edge
//            rst_n     asynchronous active-low reset
//            din       [9:8] opcode, [7:0] address / data
//            rx_valid  din valid (may be held high several cycles)
//            dout      read byte back to the slave
//            tx_valid  dout valid level, held until a non-read word arrives
//            err       one-cycle pulse on an illegal or out-of-range command
// Revision : 1.0  initial release
// ============================================================================
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    localparam logic [1:0] c_OP_WR_ADDR = 2'b00;
    localparam logic [1:0] c_OP_WR_DATA = 2'b01;
    localparam logic [1:0] c_OP_RD_ADDR = 2'b10;

    // Per-port sequencing state: data commands are only legal once an
    // in-range address has been latched for that port.
    localparam logic c_NO_ADDR = 1'b0;
    localparam logic c_ADDR_OK = 1'b1;

    localparam logic [8:0]           c_DEPTH = 9'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] c_LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [7:0]           r_mem [0:MEM_DEPTH-1];
    logic                 r_rx_valid_d;
    logic                 r_wr_state;
    logic                 r_rd_state;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_mem_we;
    logic [7:0]           w_rd_byte;
    logic                 w_wr_state_nxt;
    logic                 w_rd_state_nxt;
    logic [ADDR_SIZE-1:0] w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0] w_rd_addr_nxt;
    logic [7:0]           w_dout_nxt;
    logic                 w_tx_valid_nxt;
    logic                 w_err_nxt;

    // Wrap compares against the last legal index so non-power-of-two depths
    // return to 0 instead of running into unimplemented addresses.
    function automatic logic [ADDR_SIZE-1:0] f_next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == c_LAST) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    // A held rx_valid must not repeat the command, so only its rising edge counts.
    assign w_accept   = rx_valid & ~r_rx_valid_d;
    assign w_in_range = ({1'b0, din[7:0]} < c_DEPTH);
    assign w_rd_byte  = r_mem[r_rd_addr];

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_rd_state_nxt = r_rd_state;
        w_wr_addr_nxt  = r_wr_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_dout_nxt     = r_dout;
        w_tx_valid_nxt = r_tx_valid;
        w_err_nxt      = 1'b0;
        w_mem_we       = 1'b0;
        if (w_accept) begin
            // Any accepted word other than a successful read retires dout.
            w_tx_valid_nxt = 1'b0;
            case (din[9:8])
                c_OP_WR_ADDR: begin
                    if (w_in_range) begin
                        w_wr_addr_nxt  = din[ADDR_SIZE-1:0];
                        w_wr_state_nxt = c_ADDR_OK;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                c_OP_WR_DATA: begin
                    if (r_wr_state == c_ADDR_OK) begin
                        w_mem_we      = 1'b1;
                        w_wr_addr_nxt = f_next_addr(r_wr_addr);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                c_OP_RD_ADDR: begin
                    if (w_in_range) begin
                        w_rd_addr_nxt  = din[ADDR_SIZE-1:0];
                        w_rd_state_nxt = c_ADDR_OK;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: begin
                    if (r_rd_state == c_ADDR_OK) begin
                        w_dout_nxt     = w_rd_byte;
                        w_tx_valid_nxt = 1'b1;
                        w_rd_addr_nxt  = f_next_addr(r_rd_addr);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid_d <= 1'b0;
            r_wr_state   <= c_NO_ADDR;
            r_rd_state   <= c_NO_ADDR;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_dout       <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rx_valid_d <= rx_valid;
            r_wr_state   <= w_wr_state_nxt;
            r_rd_state   <= w_rd_state_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_dout       <= w_dout_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= din[7:0];
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_ctrl
// Purpose  : Scoreboard bench for spi_ram_ctrl. Two instances (depth 256 and
//            depth 200) share one stimulus stream; a word-level reference
//            model predicts the response of each accepted word and a monitor
//            compares it one cycle after the rising edge of rx_valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [1:0][7:0] dout;
    logic [1:0]      tx_valid;
    logic [1:0]      err;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout[0]), .tx_valid(tx_valid[0]), .err(err[0])
    );

    spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) u_dut200 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout[1]), .tx_valid(tx_valid[1]), .err(err[1])
    );

    typedef struct packed {
        logic [1:0]      txv;
        logic [1:0]      err;
        logic [1:0]      dk;     // dout value is known (memory was written)
        logic [1:0][7:0] dout;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state, one slot per instance.
    int         depth [2] = '{256, 200};
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wr [2];
    int         m_rd [2];
    bit         m_wv [2];
    bit         m_rv [2];
    bit         m_txv[2];
    bit         m_dk [2];
    logic [7:0] m_dout[2];

    task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = 0; m_rd[k] = 0; m_wv[k] = 0; m_rv[k] = 0;
            m_txv[k] = 0; m_dk[k] = 1; m_dout[k] = 8'h00;
        end
    endtask

    task automatic model_step(input int k, input logic [1:0] op, input logic [7:0] d, output bit e);
        e = 0;
        if (op != 2'd3) m_txv[k] = 0;
        case (op)
            2'd0: if (int'(d) < depth[k]) begin m_wr[k] = int'(d); m_wv[k] = 1; end else e = 1;
            2'd1: if (m_wv[k]) begin
                      m_mem[k][m_wr[k]] = d; m_known[k][m_wr[k]] = 1;
                      m_wr[k] = (m_wr[k] + 1) % depth[k];
                  end else e = 1;
            2'd2: if (int'(d) < depth[k]) begin m_rd[k] = int'(d); m_rv[k] = 1; end else e = 1;
            default: if (m_rv[k]) begin
                      m_dout[k] = m_mem[k][m_rd[k]]; m_dk[k] = m_known[k][m_rd[k]];
                      m_txv[k] = 1; m_rd[k] = (m_rd[k] + 1) % depth[k];
                  end else begin e = 1; m_txv[k] = 0; end
        endcase
    endtask

    // Issue one word: rx_valid high for 'hold' cycles (din scrambled after the
    // first), then low for 'gap' cycles.
    task automatic send(input logic [1:0] op, input logic [7:0] d, input int hold = 1, input int gap = 1);
        exp_t e;
        bit   er;
        @(negedge clk);
        din = {op, d};
        rx_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            model_step(k, op, d, er);
            e.err[k]  = er;
            e.txv[k]  = m_txv[k];
            e.dk[k]   = m_dk[k];
            e.dout[k] = m_dout[k];
        end
        q.push_back(e);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            din = 10'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        din = 10'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    // Monitor: a rising rx_valid seen at a clock edge means the DUT presents
    // that word's response by the following falling edge.
    initial begin : g_monitor
        bit   prev = 0;
        bit   acc;
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                prev = 0;
                acc  = 0;
            end else begin
                acc  = rx_valid & ~prev;
                prev = rx_valid;
            end
            @(negedge clk);
            if (acc) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 0, 8'd0, 8'd1);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 2; k++) begin
                        chk("err", k, {7'd0, err[k]}, {7'd0, e.err[k]});
                        chk("tx_valid", k, {7'd0, tx_valid[k]}, {7'd0, e.txv[k]});
                        if (e.dk[k]) chk("dout", k, dout[k], e.dout[k]);
                    end
                end
            end else if (rst_n) begin
                for (int k = 0; k < 2; k++) chk("err_idle", k, {7'd0, err[k]}, 8'd0);
            end
        end
    end

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : g_stim
        rst_n = 1'b0;
        rx_valid = 1'b0;
        din = '0;
        for (int k = 0; k < 2; k++) for (int a = 0; a < 256; a++) m_known[k][a] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_dout", k, dout[k], 8'h00);
            chk("rst_tx_valid", k, {7'd0, tx_valid[k]}, 8'd0);
            chk("rst_err", k, {7'd0, err[k]}, 8'd0);
        end
        rst_n = 1'b1;

        // Data commands before any address latch
        send(2'd3, 8'h00);
        send(2'd1, 8'h77);
        // Write / readback
        send(2'd0, 8'h10);
        send(2'd1, 8'hA5);
        send(2'd2, 8'h10);
        send(2'd3, 8'h00);
        // A non-read word clears tx_valid
        send(2'd0, 8'h20);
        // Burst across the top of memory
        send(2'd0, 8'hFE);
        send(2'd1, 8'h11); send(2'd1, 8'h22); send(2'd1, 8'h33);
        send(2'd2, 8'hFE);
        send(2'd3, 8'h00); send(2'd3, 8'h00); send(2'd3, 8'h00);
        // Long rx_valid: one write only
        send(2'd0, 8'h03);
        send(2'd1, 8'h5A, 5, 1);
        send(2'd1, 8'h6B);
        send(2'd2, 8'h03);
        send(2'd3, 8'h00);
        send(2'd3, 8'h00);

        // Asynchronous reset while tx_valid is high
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) chk("pre_rst_tx_valid", k, {7'd0, tx_valid[k]}, 8'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_tx_valid", k, {7'd0, tx_valid[k]}, 8'd0);
            chk("async_rst_dout", k, dout[k], 8'h00);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range read address at depth 200, then an illegal read
        send(2'd2, 8'hC8);
        send(2'd3, 8'h00);
        // Memory retained across reset
        send(2'd2, 8'h10);
        send(2'd3, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 0, 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
